// File: rtl/register_dump_unit_pkg.sv
// register_dump_unit_pkg: dump FSM encoding, register-file geometry and reset image
package register_dump_unit_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  localparam int REG_COUNT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_DATA_W-1:0] REG1_RESET = 32'd1;
  localparam logic [REG_DATA_W-1:0] REG29_RESET = 32'd252;
  function automatic logic [REG_DATA_W-1:0] reg_reset_val(input int idx);
    return idx == 1 ? REG1_RESET : idx == 29 ? REG29_RESET : '0;
  endfunction
endpackage

// File: rtl/register_dump_unit_if.sv
// register_dump_unit_if: register-file read port plus the valid/ready dump stream
interface register_dump_unit_if
  import register_dump_unit_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  modport master (
    output rd_addr, rd_en, out_valid, out_data, out_index, out_last,
    input  rd_data, out_ready
  );
  modport slave (
    input  rd_addr, rd_en, out_valid, out_data, out_index, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/register_dump_unit.sv
// register_dump_unit: walks REG_FIRST..REG_LAST through one read port and streams each value out
module register_dump_unit
  import register_dump_unit_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int REG_FIRST = 0,
  parameter int REG_LAST  = 31,
  parameter int RD_LAT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  register_dump_unit_if.master bus,
  output logic                busy,
  output logic                done
);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(REG_FIRST);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(REG_LAST);
  localparam logic [LAT_W-1:0]  LAT_END = LAT_W'(RD_LAT - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, index_q, index_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, last_q, last_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        idx_d   = FIRST;
        lat_d   = '0;
      end
      FETCH: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_END) begin
          data_d  = bus.rd_data;
          index_d = idx_q;
          last_d  = idx_q == LAST;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: if (bus.out_ready) begin
        valid_d = 1'b0;
        state_d = idx_q == LAST ? DONE : FETCH;
        idx_d   = idx_q == LAST ? idx_q : idx_q + ADDR_W'(1);
        lat_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = FIRST;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
      lat_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  // idx_q is the read address itself, so it stays put for the whole fetch
  assign bus.rd_addr   = idx_q;
  assign bus.rd_en     = state_q != IDLE;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
endmodule

// File: tb/tb_register_dump_unit.sv
// tb_register_dump_unit: directed dumps against a registered-read register file and a beat scoreboard
module tb_register_dump_unit;
  import register_dump_unit_pkg::*;
  typedef struct {int idx; logic [31:0] data; logic last;} beat_t;
  logic clk = 0, reset = 0, start = 0, start_b = 0;
  logic busy, done, busy_b, done_b;
  logic we = 0;
  logic [4:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem [REG_COUNT];
  logic [31:0] shadow [REG_COUNT];
  beat_t exp_a[$], exp_b[$];
  int total = 0, bad = 0, cyc = 0;
  int beats_a = 0, beats_b = 0, done_a = 0, done_bc = 0;
  int done_cyc_a = 0, done_cyc_b = 0, hs_cyc_b = 0;
  register_dump_unit_if bus_a ();
  register_dump_unit_if bus_b ();
  register_dump_unit dut (.clk(clk), .reset(reset), .start(start), .bus(bus_a), .busy(busy), .done(done));
  register_dump_unit #(.REG_FIRST(29), .REG_LAST(31)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b), .busy(busy_b), .done(done_b)
  );
  assign bus_b.out_ready = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we) mem[waddr] <= wdata;
    bus_a.rd_data <= mem[bus_a.rd_en ? bus_a.rd_addr : 5'd0];
    bus_b.rd_data <= mem[bus_b.rd_addr];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (reset) begin : mon_a
    beat_t e;
    if (bus_a.out_valid && bus_a.out_ready) begin
      if (exp_a.size() > 0) e = exp_a.pop_front();
      else begin e.idx = -1; e.data = '1; e.last = 1'b0; end
      check("a_index", 32'(bus_a.out_index), e.idx);
      check("a_data", bus_a.out_data, e.data);
      check("a_last", 32'(bus_a.out_last), 32'(e.last));
      beats_a++;
    end
    if (done) begin done_a++; done_cyc_a = cyc; end
  end
  always @(negedge clk) if (reset) begin : mon_b
    beat_t e;
    if (bus_b.out_valid && bus_b.out_ready) begin
      if (exp_b.size() > 0) e = exp_b.pop_front();
      else begin e.idx = -1; e.data = '1; e.last = 1'b0; end
      check("b_index", 32'(bus_b.out_index), e.idx);
      check("b_data", bus_b.out_data, e.data);
      check("b_last", 32'(bus_b.out_last), 32'(e.last));
      beats_b++;
      hs_cyc_b = cyc;
    end
    if (done_b) begin done_bc++; done_cyc_b = cyc; end
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic push_range(input int first, input int last, input bit to_b);
    for (int i = first; i <= last; i++) begin
      beat_t b;
      b.idx = i; b.data = shadow[i]; b.last = (i == last);
      if (to_b) exp_b.push_back(b); else exp_a.push_back(b);
    end
  endtask
  task automatic start_a(output int sc);
    start = 1; sc = cyc; tick(1); start = 0;
  endtask
  task automatic wait_done(input bit on_b, input int prev, input int budget);
    logic seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = on_b ? done_bc > prev : done_a > prev;
    end
    check(on_b ? "b_done_seen" : "a_done_seen", 32'(seen), 1);
  endtask
  task automatic wait_index_a(input int idx);
    logic found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1);
      found = bus_a.out_valid && bus_a.out_index == 5'(idx);
    end
    check("a_reach_idx", 32'(found), 1);
  endtask
  task automatic full_dump_a(input string tag);
    int sc, d0, b0;
    push_range(0, 31, 0);
    d0 = done_a; b0 = beats_a;
    start_a(sc);
    wait_done(0, d0, 300);
    tick(4);
    check({tag, "_cycles"}, done_cyc_a - sc, 97);
    check({tag, "_beats"}, beats_a - b0, 32);
    check({tag, "_dones"}, done_a - d0, 1);
    check({tag, "_queue"}, exp_a.size(), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    int sc, d0, b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      shadow[i] = reg_reset_val(i);
      mem[i] = shadow[i];
    end
    bus_a.out_ready = 1;
    tick(3);
    check("rst_valid", 32'(bus_a.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(bus_a.rd_en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_addr", 32'(bus_a.rd_addr), 0);
    check("rst_data", bus_a.out_data, 0);
    check("rst_index", 32'(bus_a.out_index), 0);
    check("rst_last", 32'(bus_a.out_last), 0);
    check("rst_b_rd_addr", 32'(bus_b.rd_addr), 29);
    reset = 1;
    tick(2);
    check("idle_no_start", 32'(busy), 0);
    full_dump_a("dump1");
    push_range(0, 31, 0);
    d0 = done_a; b0 = beats_a;
    start_a(sc);
    wait_index_a(3);
    bus_a.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus_a.out_valid), 1);
      check("stall_index", 32'(bus_a.out_index), 3);
      check("stall_data", bus_a.out_data, shadow[3]);
      tick(1);
    end
    bus_a.out_ready = 1;
    wait_done(0, d0, 300);
    tick(4);
    check("bp_beats", beats_a - b0, 32);
    check("bp_dones", done_a - d0, 1);
    check("bp_queue", exp_a.size(), 0);
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick(1);
    we = 0; shadow[5] = 32'hDEADBEEF;
    tick(1);
    push_range(0, 31, 0);
    d0 = done_a; b0 = beats_a;
    start_a(sc);
    wait_index_a(7);
    start = 1;
    tick(1);
    start = 0;
    wait_done(0, d0, 300);
    tick(6);
    check("mid_start_beats", beats_a - b0, 32);
    check("mid_start_dones", done_a - d0, 1);
    check("mid_start_queue", exp_a.size(), 0);
    push_range(0, 31, 0);
    d0 = done_a;
    start_a(sc);
    wait_index_a(10);
    #2 reset = 0;
    #1;
    check("async_valid", 32'(bus_a.out_valid), 0);
    check("async_busy", 32'(busy), 0);
    check("async_rd_en", 32'(bus_a.rd_en), 0);
    exp_a.delete();
    tick(3);
    reset = 1;
    tick(3);
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_no_done", done_a - d0, 0);
    full_dump_a("after_rst");
    push_range(29, 31, 1);
    d0 = done_bc; b0 = beats_b;
    start_b = 1; sc = cyc;
    tick(1);
    start_b = 0;
    wait_done(1, d0, 100);
    tick(3);
    check("b_beats", beats_b - b0, 3);
    check("b_dones", done_bc - d0, 1);
    check("b_cycles", done_cyc_b - sc, 10);
    check("b_hs_to_done", done_cyc_b - hs_cyc_b, 1);
    check("b_queue", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
